// File: rtl/rr_arbiter_n_if.sv
// Request/grant bundle between the requesters and rr_arbiter_n.
// master = requester side, slave = arbiter side.
interface rr_arbiter_n_if #(
  parameter int N = 4
) ();
  localparam int IW = $clog2(N);

  logic [N-1:0]  REQ;
  logic          ACK;
  logic [N-1:0]  GRANT;
  logic [IW-1:0] GRANT_ID;
  logic          GRANT_VLD;
  logic          TOUT;

  modport master (
    output REQ, ACK,
    input  GRANT, GRANT_ID, GRANT_VLD, TOUT
  );

  modport slave (
    input  REQ, ACK,
    output GRANT, GRANT_ID, GRANT_VLD, TOUT
  );
endinterface

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter for N requesters. Each grant ends on ACK, on request drop,
// or after QUANTA cycles, and then rotates directly to the next requester.
module rr_arbiter_n #(
  parameter int N      = 4,
  parameter int QUANTA = 4
) (
  input  logic          CLK,
  input  logic          RSTN,
  rr_arbiter_n_if.slave bus
);
  localparam int          IW       = $clog2(N);
  localparam int          CW       = (QUANTA > 1) ? $clog2(QUANTA) : 1;
  localparam int unsigned NU       = N;
  localparam logic [CW-1:0] CNT_LAST = CW'(QUANTA - 1);
  localparam logic [IW-1:0] PTR_INIT = IW'(N - 1);
  localparam logic [N-1:0]  ONE      = N'(1);

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic          found;
    logic [IW-1:0] idx;
  } pick_t;

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] id_q, id_d;
  logic          vld_q, vld_d;
  logic          tout_q, tout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] last_q, last_d;

  logic  expire;
  logic  rel;
  pick_t nxt;

  // First requester strictly after 'from', wrapping, with 'from' itself checked last.
  function automatic pick_t pick(input logic [N-1:0] req, input logic [IW-1:0] from);
    pick_t       r;
    int unsigned idx;
    r = '0;
    for (int unsigned k = 1; k <= NU; k++) begin
      idx = (32'(from) + k) % NU;
      if (!r.found && req[idx[IW-1:0]]) begin
        r.found = 1'b1;
        r.idx   = idx[IW-1:0];
      end
    end
    return r;
  endfunction

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      vld_q   <= 1'b0;
      tout_q  <= 1'b0;
      cnt_q   <= '0;
      last_q  <= PTR_INIT;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      vld_q   <= vld_d;
      tout_q  <= tout_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    tout_d  = 1'b0;

    expire = (cnt_q == CNT_LAST);
    rel    = bus.ACK | expire | ~bus.REQ[id_q];
    // While busy the scan starts after the holder; last_q tracks it for the idle case.
    nxt    = pick(bus.REQ, (state_q == BUSY) ? id_q : last_q);

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (nxt.found) begin
          state_d = BUSY;
          grant_d = ONE << nxt.idx;
          id_d    = nxt.idx;
          vld_d   = 1'b1;
          last_d  = nxt.idx;
        end
      end
      BUSY: begin
        if (!rel) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          tout_d = expire & ~bus.ACK & bus.REQ[id_q];
          cnt_d  = '0;
          if (nxt.found) begin
            grant_d = ONE << nxt.idx;
            id_d    = nxt.idx;
            last_d  = nxt.idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            id_d    = '0;
            vld_d   = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.GRANT     = grant_q;
    bus.GRANT_ID  = id_q;
    bus.GRANT_VLD = vld_q;
    bus.TOUT      = tout_q;
  end

  a_onehot: assert property (@(posedge CLK) disable iff (!RSTN) $onehot0(grant_q));
  a_vld:    assert property (@(posedge CLK) disable iff (!RSTN) vld_q == |grant_q);
  a_id:     assert property (@(posedge CLK) disable iff (!RSTN) !vld_q || grant_q[id_q]);
  a_cnt:    assert property (@(posedge CLK) disable iff (!RSTN) cnt_q <= CNT_LAST);
  a_idle:   assert property (@(posedge CLK) disable iff (!RSTN) (state_q == IDLE) -> (cnt_q == '0 && !vld_q));
endmodule

// File: tb/tb_rr_arbiter_n.sv
// Bench for rr_arbiter_n: directed vector table, async-reset sequence, and
// randomized traffic against a cycle-level reference model, on N=4/Q=4 and N=8/Q=1.
module tb_rr_arbiter_n;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   errors = 0;
  int   checks = 0;

  rr_arbiter_n_if #(.N(4)) ifa ();
  rr_arbiter_n_if #(.N(8)) ifb ();

  rr_arbiter_n #(.N(4), .QUANTA(4)) dut_a (.CLK(clk), .RSTN(rst_a), .bus(ifa));
  rr_arbiter_n #(.N(8), .QUANTA(1)) dut_b (.CLK(clk), .RSTN(rst_b), .bus(ifb));

  // Reference model: who holds the resource and for how many cycles so far.
  typedef struct {
    bit busy;
    int owner;
    int held;
    int last;
    bit tout;
  } mdl_t;

  function automatic mdl_t mdl_reset(input int n);
    mdl_t s;
    s.busy = 0; s.owner = 0; s.held = 0; s.last = n - 1; s.tout = 0;
    return s;
  endfunction

  function automatic int pick(input int unsigned req, input int from, input int n);
    for (int k = 1; k <= n; k++) begin
      if (req[(from + k) % n]) return (from + k) % n;
    end
    return -1;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t s, input int n, input int q,
                                    input int unsigned req, input bit ack);
    mdl_t t;
    int   p;
    bit   expire, rel;
    t = s;
    t.tout = 0;
    if (!s.busy) begin
      p = pick(req, s.last, n);
      if (p >= 0) begin
        t.busy = 1; t.owner = p; t.held = 1; t.last = p;
      end
    end else begin
      expire = (s.held == q);
      rel    = ack || expire || !req[s.owner];
      if (!rel) t.held = s.held + 1;
      else begin
        t.tout = expire && !ack && req[s.owner];
        p = pick(req, s.owner, n);
        if (p >= 0) begin
          t.owner = p; t.held = 1; t.last = p;
        end else begin
          t.busy = 0; t.owner = 0; t.held = 0;
        end
      end
    end
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_a(input string tag, input mdl_t s);
    chk({tag, ".grant"}, 32'(ifa.GRANT),     s.busy ? (32'd1 << s.owner) : 32'd0);
    chk({tag, ".id"},    32'(ifa.GRANT_ID),  32'(s.owner));
    chk({tag, ".vld"},   32'(ifa.GRANT_VLD), 32'(s.busy));
    chk({tag, ".tout"},  32'(ifa.TOUT),      32'(s.tout));
  endtask

  task automatic chk_b(input string tag, input mdl_t s);
    chk({tag, ".grant"}, 32'(ifb.GRANT),     s.busy ? (32'd1 << s.owner) : 32'd0);
    chk({tag, ".id"},    32'(ifb.GRANT_ID),  32'(s.owner));
    chk({tag, ".vld"},   32'(ifb.GRANT_VLD), 32'(s.busy));
    chk({tag, ".tout"},  32'(ifb.TOUT),      32'(s.tout));
  endtask

  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic [3:0] g;
    logic [1:0] id;
    logic       v;
    logic       t;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int cnt, input logic [3:0] req, input logic ack,
                              input logic [3:0] g, input logic [1:0] id,
                              input logic v, input logic t);
    vec_t e;
    e.req = req; e.ack = ack; e.g = g; e.id = id; e.v = v; e.t = t;
    for (int i = 0; i < cnt; i++) vecs.push_back(e);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mdl_t        ma, mb;
    logic [3:0]  ra;
    logic [7:0]  rb;
    logic        ack;

    // first grant after reset, rotation by timeout
    add(1, 4'b1010, 0, 4'b0010, 1, 1, 0);
    add(3, 4'b1111, 0, 4'b0010, 1, 1, 0);
    add(1, 4'b1111, 0, 4'b0100, 2, 1, 1);
    add(3, 4'b1111, 0, 4'b0100, 2, 1, 0);
    add(1, 4'b1111, 0, 4'b1000, 3, 1, 1);
    add(3, 4'b1111, 0, 4'b1000, 3, 1, 0);
    add(1, 4'b1111, 0, 4'b0001, 0, 1, 1);
    // early ACK in owner 0's second cycle, then owner 2 runs a full quantum
    add(1, 4'b0101, 0, 4'b0001, 0, 1, 0);
    add(1, 4'b0101, 1, 4'b0100, 2, 1, 0);
    add(3, 4'b0101, 0, 4'b0100, 2, 1, 0);
    add(1, 4'b0101, 0, 4'b0001, 0, 1, 1);
    // request drop to IDLE, pointer persists
    add(1, 4'b0100, 0, 4'b0100, 2, 1, 0);
    add(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
    add(1, 4'b0000, 1, 4'b0000, 0, 0, 0);
    add(1, 4'b0101, 0, 4'b0001, 0, 1, 0);
    // ACK in the expiry cycle suppresses TOUT
    add(3, 4'b0101, 0, 4'b0001, 0, 1, 0);
    add(1, 4'b0101, 1, 4'b0100, 2, 1, 0);
    // request drop in the expiry cycle suppresses TOUT
    add(3, 4'b0101, 0, 4'b0100, 2, 1, 0);
    add(1, 4'b0001, 0, 4'b0001, 0, 1, 0);
    // sole requester re-granted after timeout
    add(3, 4'b0001, 0, 4'b0001, 0, 1, 0);
    add(1, 4'b0001, 0, 4'b0001, 0, 1, 1);

    rst_a = 1'b0; rst_b = 1'b0;
    ifa.REQ = '0; ifa.ACK = 1'b0;
    ifb.REQ = '0; ifb.ACK = 1'b0;
    @(negedge clk);
    ma = mdl_reset(4);
    mb = mdl_reset(8);
    chk_a("reset_a", ma);
    chk_b("reset_b", mb);

    rst_a = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      ifa.REQ = vecs[i].req;
      ifa.ACK = vecs[i].ack;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d.grant", i), 32'(ifa.GRANT),     32'(vecs[i].g));
      chk($sformatf("vec%0d.id", i),    32'(ifa.GRANT_ID),  32'(vecs[i].id));
      chk($sformatf("vec%0d.vld", i),   32'(ifa.GRANT_VLD), 32'(vecs[i].v));
      chk($sformatf("vec%0d.tout", i),  32'(ifa.TOUT),      32'(vecs[i].t));
    end

    // asynchronous reset while requester 2 holds the grant
    ifa.REQ = 4'b0100; ifa.ACK = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst.grant", 32'(ifa.GRANT), 32'h4);
    #2 rst_a = 1'b0;
    #1;
    chk("async_rst.grant", 32'(ifa.GRANT),     32'h0);
    chk("async_rst.vld",   32'(ifa.GRANT_VLD), 32'h0);
    chk("async_rst.id",    32'(ifa.GRANT_ID),  32'h0);
    @(negedge clk);
    rst_a = 1'b1;
    ifa.REQ = 4'b1100;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst.grant", 32'(ifa.GRANT),    32'h4);
    chk("post_rst.id",    32'(ifa.GRANT_ID), 32'h2);

    // randomized traffic, N=4 QUANTA=4
    rst_a = 1'b0; ifa.REQ = '0; ifa.ACK = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    ma = mdl_reset(4);
    ra = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) ra = 4'($urandom_range(0, 15));
      ack = ($urandom_range(0, 3) == 0);
      ifa.REQ = ra; ifa.ACK = ack;
      @(posedge clk);
      ma = mdl_step(ma, 4, 4, 32'(ra), ack);
      @(negedge clk);
      chk_a($sformatf("rnd_a%0d", i), ma);
    end

    // N=8 QUANTA=1, sole requester 5
    rst_b = 1'b1;
    ifb.REQ = 8'h20; ifb.ACK = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      mb = mdl_step(mb, 8, 1, 32'h20, 1'b0);
      @(negedge clk);
      chk($sformatf("q1_%0d.grant", i), 32'(ifb.GRANT),     32'h20);
      chk($sformatf("q1_%0d.id", i),    32'(ifb.GRANT_ID),  32'd5);
      chk($sformatf("q1_%0d.vld", i),   32'(ifb.GRANT_VLD), 32'd1);
      chk($sformatf("q1_%0d.tout", i),  32'(ifb.TOUT),      (i == 0) ? 32'd0 : 32'd1);
    end

    // randomized traffic, N=8 QUANTA=1
    rb = 8'h20;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) < 4) rb = 8'($urandom_range(0, 255));
      ack = ($urandom_range(0, 3) == 0);
      ifb.REQ = rb; ifb.ACK = ack;
      @(posedge clk);
      mb = mdl_step(mb, 8, 1, 32'(rb), ack);
      @(negedge clk);
      chk_b($sformatf("rnd_b%0d", i), mb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_n.md
Name: rr_arbiter_n

Overview:
- Parametrised round-robin arbiter for N requesters. Grants exclusive access to one shared resource.
- Each grant lasts until ACK, until the holder drops its request, or until a time quantum of QUANTA cycles expires.
- Next-generation arbiter for the shared-bus subsystem. Adds:
  - an N-wide request vector;
  - a per-grant timeout counter that restarts on every new grant;
  - a round-robin pointer that persists through IDLE;
  - an encoded grant index;
  - a timeout indication.

Parameters:
- N, 4, number of requesters (N >= 2).
- QUANTA, 4, maximum grant length in cycles before forced rotation (QUANTA >= 1).
- IW, $clog2(N), width of the GRANT_ID port (derived; do not override).

Ports:
- CLK  in  1  clock, rising-edge.
- RSTN  in  1  asynchronous active-low reset.
- REQ  in  N  request vector; bit i = requester i wants the resource.
- ACK  in  1  current holder finished; release the grant this cycle.
- GRANT  out  N  one-hot grant (all-zero when idle), registered.
- GRANT_ID  out  IW  binary index of the current holder; 0 when idle, registered.
- GRANT_VLD  out  1  high when any GRANT bit is set, registered.
- TOUT  out  1  one-cycle pulse: the previous grant was revoked by quantum expiry, registered.

Behaviour:
- Reset (RSTN low, asynchronous):
  - GRANT=0, GRANT_ID=0, GRANT_VLD=0, TOUT=0.
  - State=IDLE, quantum counter=0, round-robin pointer last=N-1, so requester 0 wins first after reset.
- State is IDLE or BUSY; owner is held in GRANT_ID.
- All outputs change only on the CLK rising edge. Latency from REQ to GRANT out of IDLE is one cycle.
- Selection function pick(last): the first i with REQ[i]=1, scanning last+1, last+2, ... wrapping modulo N, ending at last itself. Returns none if REQ=0.
- IDLE:
  - If REQ!=0: go to BUSY with owner=pick(last), counter=0, last=owner.
  - Else stay IDLE.
  - ACK is ignored in IDLE.
- BUSY, release condition rel = ACK | expire | ~REQ[owner], where expire = (counter == QUANTA-1).
  - If rel=0: counter increments and the owner is held.
  - If rel=1 and pick(owner) exists: grant moves directly to pick(owner) with no idle cycle. counter=0, last=new owner.
  - If rel=1 and pick(owner) does not exist: go to IDLE with GRANT=0. last keeps the old owner.
  - If the owner is the only requester, it is re-granted after release; counter restarts at 0.
- Maximum grant length: a grant never stays high for more than QUANTA consecutive cycles without the counter restarting.
  - QUANTA=1 means every grant lasts exactly one cycle.
- TOUT:
  - Asserted for one cycle on the edge that acts on a release where expire=1, ACK=0 and REQ[owner]=1.
  - Deasserted on every other edge.
  - ACK or a dropped request in the expiry cycle takes precedence: no TOUT.
- Counter:
  - Width max(1, $clog2(QUANTA)). It never exceeds QUANTA-1 and never wraps silently.
  - It is held at 0 in IDLE.
- Invariants:
  - GRANT is always one-hot or zero.
  - GRANT_VLD == |GRANT.
  - GRANT_ID equals the encoded GRANT whenever GRANT_VLD=1.
- Requests with X/Z are not supported. REQ and ACK are synchronous to CLK.
- Mid-operation reset: when RSTN asserts, all outputs clear immediately, without waiting for a clock edge. After release, the first grant goes to the lowest-index requester.

Test Plan:
- Reset/first grant: hold RSTN=0, then release with REQ=4'b1010 -> one edge later GRANT=4'b0010, GRANT_ID=1, GRANT_VLD=1, TOUT=0.
- Timeout rotation: N=4, QUANTA=4, REQ=4'b1111 held, ACK=0 -> each grant lasts exactly 4 cycles, in order 0001,0010,0100,1000,0001. TOUT pulses one cycle at each switch.
- ACK early release: REQ=4'b0101, ACK pulsed in the 2nd cycle of owner 0 -> GRANT becomes 0100 on the next edge, no TOUT. Owner 2 then holds for 4 cycles.
- Request drop and IDLE pointer: owner 2, REQ drops to 0 -> IDLE. Then REQ=4'b0101 -> grant goes to 0 (scan starts at 3), not 2.
- Sole requester and QUANTA=1 corner: N=8, QUANTA=1, REQ=8'h20 held -> GRANT=8'h20 every cycle, GRANT_ID=5, TOUT=1 every cycle after the first grant.
- Async reset mid-grant: assert RSTN low between clock edges while GRANT=0100 -> GRANT=0, GRANT_VLD=0 immediately. After release with REQ=4'b1100 -> GRANT=0100.
